// File: rtl/mem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_if
// Request/acknowledge bus between the memory-access stage and external
// 16-bit word-addressed memory.
//
// Signals:
//   bus_req    request, held until the access completes or is aborted
//   bus_we     1 = write, 0 = read
//   bus_addr   word address
//   bus_wdata  write data
//   bus_rdata  read data, valid while bus_ack is high
//   bus_ack    transfer complete
//
// Modports:
//   master  the controller (drives req/we/addr/wdata)
//   slave   the memory (drives rdata/ack)
// -----------------------------------------------------------------------------
interface mem_bus_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ack
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ack
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// This is the memory-access stage that sits after the instruction decoder.
// It takes the decoder read/write strobes, the address and the ALU write data.
// From these it runs one registered req/ack transaction on the external bus.
// The core is stalled until that transaction completes.
// Read data is then presented as the R_MEM source value.
//
// Parameters:
//   TIMEOUT_CYC   BUSY cycles without ack before the access is aborted (1..65535)
//
// Ports:
//   i_clk          core clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_mem_rd       decoder read strobe
//   i_mem_wr       decoder write strobe
//   i_addr         access address
//   i_wdata        write data
//   o_stall        hold the decoder and register writes this cycle
//   o_rdata        read data for the R_MEM source path
//   o_rdata_valid  o_rdata belongs to the access completing this cycle
//   o_err          one-cycle pulse: timeout, or rd and wr together
//   bus            external memory bus (master side)
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_mem_rd,
   input  logic                  i_mem_wr,
   input  logic [15:0]           i_addr,
   input  logic [15:0]           i_wdata,
   output logic                  o_stall,
   output logic [15:0]           o_rdata,
   output logic                  o_rdata_valid,
   output logic                  o_err,
   mem_bus_ctrl_if.master        bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // The last wait cycle index at which a missing ack aborts the access.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [15:0] wait_cnt;

   // The stall is combinational so the decoder freezes in the same cycle it
   // raises a strobe. The stall is always held during BUSY. It is released in
   // DONE so the decoder can retire the state that issued the access.
   always_comb begin
      o_stall = 1'b0;
      case (state)
         IDLE:    o_stall = i_mem_rd | i_mem_wr;
         BUSY:    o_stall = 1'b1;
         default: o_stall = 1'b0;
      endcase
   end

   // Main controller. All bus outputs are registered. Reset drops the request
   // at once and reports no completion. o_err and o_rdata_valid are
   // single-cycle pulses, so they default low every cycle and are only set on
   // the transition that produces them. When both strobes are asserted, the
   // access is issued as a write and flagged. On a timeout, a read returns
   // all-ones so the decoder never sees stale data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         wait_cnt      <= 16'd0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 16'd0;
         bus.bus_wdata <= 16'd0;
         o_rdata       <= 16'd0;
         o_rdata_valid <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         o_err         <= 1'b0;
         o_rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_mem_rd || i_mem_wr) begin
                  bus.bus_addr  <= i_addr;
                  bus.bus_wdata <= i_wdata;
                  bus.bus_we    <= i_mem_wr;
                  bus.bus_req   <= 1'b1;
                  wait_cnt      <= 16'd0;
                  o_err         <= i_mem_rd & i_mem_wr;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               if (bus.bus_ack) begin
                  bus.bus_req   <= 1'b0;
                  if (!bus.bus_we) begin
                     o_rdata <= bus.bus_rdata;
                  end
                  o_rdata_valid <= 1'b1;
                  state         <= DONE;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  bus.bus_req   <= 1'b0;
                  if (!bus.bus_we) begin
                     o_rdata <= 16'hFFFF;
                  end
                  o_rdata_valid <= 1'b1;
                  o_err         <= 1'b1;
                  state         <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            DONE: begin
               // Strobes seen here still belong to the access just retired.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Directed bench for mem_bus_ctrl with TIMEOUT_CYC = 4.
// Each access pushes its expected completion onto a scoreboard queue.
// The entry is popped when the DUT signals o_rdata_valid.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

   localparam int TIMEOUT_CYC = 4;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          busy;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        stall;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        err;

   exp_t        sb_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cycle_num  = 0;
   logic [15:0] model_rdata = 16'd0;
   int          req_rd_cycle;
   int          req_wr_cycle;
   int          req_tmp;

   mem_bus_ctrl_if bus ();

   mem_bus_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_mem_rd      (mem_rd),
      .i_mem_wr      (mem_wr),
      .i_addr        (addr),
      .i_wdata       (wdata),
      .o_stall       (stall),
      .o_rdata       (rdata),
      .o_rdata_valid (rdata_valid),
      .o_err         (err),
      .bus           (bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure request spacing
   always @(posedge clk) cycle_num <= cycle_num + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // This is one idle cycle with no strobes. An ack can optionally be driven
   // to show that it is ignored.
   task automatic idleCycle(input string tag, input logic ack, input logic [15:0] ack_data);
      @(negedge clk);
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      bus.bus_ack   = ack;
      bus.bus_rdata = ack_data;
      #1;
      checkOutput({tag, ".req"},   bus.bus_req, 0);
      checkOutput({tag, ".stall"}, stall, 0);
      checkOutput({tag, ".valid"}, rdata_valid, 0);
      checkOutput({tag, ".err"},   err, 0);
      checkOutput({tag, ".rdata"}, rdata, model_rdata);
   endtask

   // This runs one full access: the IDLE request cycle, the BUSY cycles and
   // the DONE cycle. ack_at is the BUSY cycle that receives the ack; 0 means
   // the ack never arrives. done_rd and done_wr are the strobes driven during
   // DONE.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                input int ack_at, input logic [15:0] ack_data,
                                input logic done_rd, input logic done_wr,
                                input string tag, output int req_cycle);
      exp_t e;
      exp_t got;
      int   busy;
      bit   done;

      // IDLE request cycle
      @(negedge clk);
      mem_rd        = rd;
      mem_wr        = wr;
      addr          = a;
      wdata         = wd;
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 16'h5A5A;
      #1;
      checkOutput({tag, ".idle_stall"}, stall, 1);
      checkOutput({tag, ".idle_req"},   bus.bus_req, 0);

      e.busy  = (ack_at != 0) ? ack_at : TIMEOUT_CYC;
      e.err   = (ack_at == 0);
      e.rdata = wr ? model_rdata : ((ack_at != 0) ? ack_data : 16'hFFFF);
      sb_q.push_back(e);
      model_rdata = e.rdata;

      busy      = 0;
      done      = 0;
      req_cycle = -1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (rdata_valid === 1'b1) begin
            done = 1;
         end else begin
            busy++;
            if (busy == 1) req_cycle = cycle_num;
            bus.bus_ack   = (busy == ack_at);
            bus.bus_rdata = (busy == ack_at) ? ack_data : 16'h5A5A;
            #1;
            checkOutput({tag, ".busy_req"},   bus.bus_req, 1);
            checkOutput({tag, ".busy_we"},    bus.bus_we, wr);
            checkOutput({tag, ".busy_addr"},  bus.bus_addr, a);
            checkOutput({tag, ".busy_wdata"}, bus.bus_wdata, wd);
            checkOutput({tag, ".busy_stall"}, stall, 1);
            checkOutput({tag, ".busy_err"},   err, (busy == 1) ? (rd & wr) : 1'b0);
         end
      end
      checkOutput({tag, ".done_seen"}, done, 1);

      // DONE cycle: strobes are ignored and the stall is released
      bus.bus_ack = 1'b0;
      mem_rd      = done_rd;
      mem_wr      = done_wr;
      #1;
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         checkOutput({tag, ".done_rdata"}, rdata, got.rdata);
         checkOutput({tag, ".done_err"},   err, got.err);
         checkOutput({tag, ".busy_cycles"}, busy, got.busy);
      end
      checkOutput({tag, ".done_stall"}, stall, 0);
      checkOutput({tag, ".done_req"},   bus.bus_req, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      addr          = 16'd0;
      wdata         = 16'd0;
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 16'd0;

      // Check the reset state
      #1;
      checkOutput("rst.req",   bus.bus_req, 0);
      checkOutput("rst.we",    bus.bus_we, 0);
      checkOutput("rst.addr",  bus.bus_addr, 0);
      checkOutput("rst.wdata", bus.bus_wdata, 0);
      checkOutput("rst.rdata", rdata, 0);
      checkOutput("rst.valid", rdata_valid, 0);
      checkOutput("rst.err",   err, 0);
      checkOutput("rst.stall", stall, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Read with no wait states
      applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'hBEEF, 1'b0, 1'b0, "rd0", req_tmp);
      idleCycle("rd0.after", 1'b0, 16'h0000);

      // Write with three wait states; the ack lands on the last legal cycle
      applyStimulus(1'b0, 1'b1, 16'hFFFE, 16'h1234, 4, 16'hDEAD, 1'b0, 1'b1, "wr3", req_tmp);
      idleCycle("wr3.after", 1'b0, 16'h0000);

      // Back-to-back: a read, then a write in the very next IDLE cycle
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1, 16'h1111, 1'b1, 1'b0, "b2b_rd", req_rd_cycle);
      applyStimulus(1'b0, 1'b1, 16'h0001, 16'h2222, 1, 16'h3333, 1'b0, 1'b1, "b2b_wr", req_wr_cycle);
      checkOutput("b2b.spacing", req_wr_cycle - req_rd_cycle, 3);
      idleCycle("b2b.no_third", 1'b0, 16'h0000);

      // Read timeout: the ack never arrives
      applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, "tmo", req_tmp);
      idleCycle("tmo.after", 1'b0, 16'h0000);

      // Both strobes together are issued as a write and flagged
      applyStimulus(1'b1, 1'b1, 16'h0777, 16'hCAFE, 1, 16'h9999, 1'b0, 1'b0, "both", req_tmp);
      idleCycle("both.after", 1'b0, 16'h0000);

      // A spurious ack while idle must have no effect
      idleCycle("spur1", 1'b1, 16'h7777);
      idleCycle("spur2", 1'b1, 16'h7777);

      // Assert reset in the middle of an access
      @(negedge clk);
      bus.bus_ack = 1'b0;
      mem_wr      = 1'b1;
      addr        = 16'h0200;
      wdata       = 16'hA5A5;
      @(negedge clk);
      #1;
      checkOutput("rstb.req_before", bus.bus_req, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstb.req",   bus.bus_req, 0);
      checkOutput("rstb.we",    bus.bus_we, 0);
      checkOutput("rstb.addr",  bus.bus_addr, 0);
      checkOutput("rstb.wdata", bus.bus_wdata, 0);
      checkOutput("rstb.rdata", rdata, 0);
      checkOutput("rstb.valid", rdata_valid, 0);
      checkOutput("rstb.err",   err, 0);
      model_rdata = 16'd0;
      mem_wr      = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle("rstb.after1", 1'b0, 16'h0000);
      idleCycle("rstb.after2", 1'b0, 16'h0000);

      checkOutput("sb.empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
